// File: rtl/ext_pkg.sv
// Shared definitions for the immediate-extension stage: the extension-mode
// encoding and its field width.
package ext_pkg;

    localparam int EXT_OP_W = 3;

    typedef enum logic [EXT_OP_W-1:0] {
        SIGN     = 3'b000,
        ZERO     = 3'b001,
        HIGH     = 3'b010,
        SIGN_SHL = 3'b011,
        ZERO_SHL = 3'b100
    } ext_op_t;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extender: turns imm/ext_op/pc into the extended
// immediate, the PC-relative branch target and a reserved-op flag.
module ext_core
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int SHAMT  = 2
) (
    input  logic [IMM_W-1:0]    imm,
    input  logic [EXT_OP_W-1:0] ext_op,
    input  logic [DATA_W-1:0]   pc,
    output logic [DATA_W-1:0]   ext_imm,
    output logic [DATA_W-1:0]   br_target,
    output logic                bad_op
);

    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

    logic signed [DATA_W-1:0] w_sext;
    logic        [DATA_W-1:0] w_zext;
    logic        [DATA_W-1:0] w_high;

    assign w_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign w_zext = {{(DATA_W-IMM_W){1'b0}}, imm};
    assign w_high = {imm, {(DATA_W-IMM_W){1'b0}}};

    always_comb begin
        ext_imm = '0;
        bad_op  = 1'b0;
        case (ext_op_t'(ext_op))
            SIGN:     ext_imm = w_sext;
            ZERO:     ext_imm = w_zext;
            HIGH:     ext_imm = w_high;
            SIGN_SHL: ext_imm = w_sext <<< SHAMT;
            ZERO_SHL: ext_imm = w_zext << SHAMT;
            default:  bad_op  = 1'b1;
        endcase
    end

    // Reserved ops leave ext_imm at zero, so the target degenerates to pc + 4.
    assign br_target = pc + PC_STEP + ext_imm;

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage: one ext_core on the input side feeding
// a main output register backed by a single skid entry (2-deep FIFO).
module imm_ext_pipe
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int SHAMT  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IMM_W-1:0]    imm,
    input  logic [EXT_OP_W-1:0] ext_op,
    input  logic [DATA_W-1:0]   pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   ext_imm,
    output logic [DATA_W-1:0]   br_target,
    output logic                bad_op
);

    logic [DATA_W-1:0] w_ext_p0;
    logic [DATA_W-1:0] w_tgt_p0;
    logic              w_bad_p0;
    logic              w_accept;
    logic              w_consume;

    logic              r_vld_p1;
    logic [DATA_W-1:0] r_ext_p1;
    logic [DATA_W-1:0] r_tgt_p1;
    logic              r_bad_p1;

    logic              r_skid_vld_p1;
    logic [DATA_W-1:0] r_skid_ext_p1;
    logic [DATA_W-1:0] r_skid_tgt_p1;
    logic              r_skid_bad_p1;

    ext_core #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W),
        .SHAMT  (SHAMT)
    ) u_core (
        .imm       (imm),
        .ext_op    (ext_op),
        .pc        (pc),
        .ext_imm   (w_ext_p0),
        .br_target (w_tgt_p0),
        .bad_op    (w_bad_p0)
    );

    assign in_ready  = !reset && !flush && !r_skid_vld_p1;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_vld_p1 && out_ready;

    // p0 -> p1: main register drives the outputs, skid absorbs one stalled accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1      <= 1'b0;
            r_ext_p1      <= '0;
            r_tgt_p1      <= '0;
            r_bad_p1      <= 1'b0;
            r_skid_vld_p1 <= 1'b0;
            r_skid_ext_p1 <= '0;
            r_skid_tgt_p1 <= '0;
            r_skid_bad_p1 <= 1'b0;
        end else if (flush) begin
            r_vld_p1      <= 1'b0;
            r_skid_vld_p1 <= 1'b0;
        end else begin
            if (!r_vld_p1 || w_consume) begin
                if (r_skid_vld_p1) begin
                    r_vld_p1 <= 1'b1;
                    r_ext_p1 <= r_skid_ext_p1;
                    r_tgt_p1 <= r_skid_tgt_p1;
                    r_bad_p1 <= r_skid_bad_p1;
                end else if (w_accept) begin
                    r_vld_p1 <= 1'b1;
                    r_ext_p1 <= w_ext_p0;
                    r_tgt_p1 <= w_tgt_p0;
                    r_bad_p1 <= w_bad_p0;
                end else begin
                    r_vld_p1 <= 1'b0;
                end
            end
            // Accept is blocked while skid is full, so these two arms never collide.
            if (w_consume && r_skid_vld_p1) begin
                r_skid_vld_p1 <= 1'b0;
            end else if (w_accept && r_vld_p1 && !out_ready) begin
                r_skid_vld_p1 <= 1'b1;
                r_skid_ext_p1 <= w_ext_p0;
                r_skid_tgt_p1 <= w_tgt_p0;
                r_skid_bad_p1 <= w_bad_p0;
            end
        end
    end

    assign out_valid = r_vld_p1;
    assign ext_imm   = r_ext_p1;
    assign br_target = r_tgt_p1;
    assign bad_op    = r_bad_p1;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: mode sweep, backpressure, flush, reserved op,
// mid-stream reset and PC wrap-around, with hand-computed expectations.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm;
    logic [2:0]  ext_op;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ext_imm;
    logic [31:0] br_target;
    logic        bad_op;

    int n_pass  = 0;
    int n_total = 0;

    imm_ext_pipe #(
        .IMM_W  (16),
        .DATA_W (32),
        .SHAMT  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .ext_op    (ext_op),
        .pc        (pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ext_imm   (ext_imm),
        .br_target (br_target),
        .bad_op    (bad_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] i, input logic [2:0] op, input logic [31:0] p);
        in_valid = 1'b1;
        imm      = i;
        ext_op   = op;
        pc       = p;
        tick();
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_ext,
                           input logic [31:0] e_tgt, input logic e_bad);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_ext"}, ext_imm, e_ext);
        chk({tag, "_tgt"}, br_target, e_tgt);
        chk({tag, "_bad"}, 32'(bad_op), 32'(e_bad));
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        imm       = '0;
        ext_op    = '0;
        pc        = '0;
        tick();
        tick();
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_ext", ext_imm, 32'd0);
        chk("rst_tgt", br_target, 32'd0);
        chk("rst_bad", 32'(bad_op), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_rdy", 32'(in_ready), 32'd1);

        // Mode sweep, back-to-back with out_ready high
        offer(16'h8000, 3'b000, 32'h0000_3000);
        chk_out("sign", 32'hFFFF_8000, 32'hFFFF_B004, 1'b0);
        offer(16'h8000, 3'b001, 32'h0000_3000);
        chk_out("zero", 32'h0000_8000, 32'h0000_B004, 1'b0);
        offer(16'h1234, 3'b010, 32'h0000_3000);
        chk_out("high", 32'h1234_0000, 32'h1234_3004, 1'b0);
        offer(16'hFFFF, 3'b011, 32'h0000_3000);
        chk_out("sshl", 32'hFFFF_FFFC, 32'h0000_3000, 1'b0);
        offer(16'h0001, 3'b100, 32'h0000_3000);
        chk_out("zshl", 32'h0000_0004, 32'h0000_3008, 1'b0);

        // Reserved op, then wrap-around entry clears bad_op
        offer(16'h5555, 3'b111, 32'h0040_0000);
        chk_out("rsvd", 32'h0000_0000, 32'h0040_0004, 1'b1);
        offer(16'h0010, 3'b000, 32'hFFFF_FFFC);
        chk_out("wrap", 32'h0000_0010, 32'h0000_0010, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("drain_vld", 32'(out_valid), 32'd0);

        // Backpressure: A to main, B to skid, C waits
        out_ready = 1'b0;
        offer(16'h000A, 3'b001, 32'h0);
        chk_out("bp_a", 32'h0000_000A, 32'h0000_000E, 1'b0);
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        offer(16'h000B, 3'b001, 32'h0);
        chk("bp_rdy2", 32'(in_ready), 32'd0);
        chk("bp_hold1", ext_imm, 32'h0000_000A);
        offer(16'h000C, 3'b001, 32'h0);
        chk("bp_hold2", ext_imm, 32'h0000_000A);
        chk("bp_rdy3", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        chk_out("bp_b", 32'h0000_000B, 32'h0000_000F, 1'b0);
        chk("bp_rdy4", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk_out("bp_c", 32'h0000_000C, 32'h0000_0010, 1'b0);
        tick();
        chk("bp_end_vld", 32'(out_valid), 32'd0);

        // Flush with both entries full and an input offered
        out_ready = 1'b0;
        offer(16'h0021, 3'b000, 32'h0);
        offer(16'h0022, 3'b000, 32'h0);
        chk("fl_full", 32'(in_ready), 32'd0);
        imm   = 16'h0023;
        flush = 1'b1;
        #1;
        chk("fl_rdy_hi", 32'(in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("fl_vld", 32'(out_valid), 32'd0);
        chk("fl_rdy", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("fl_noacc", 32'(out_valid), 32'd0);

        // Reset mid-stream, then 1-cycle latency on first accept
        out_ready = 1'b0;
        offer(16'h0031, 3'b111, 32'h0);
        offer(16'h0032, 3'b000, 32'h0);
        chk("mr_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        chk("mr_vld", 32'(out_valid), 32'd0);
        chk("mr_ext", ext_imm, 32'd0);
        chk("mr_tgt", br_target, 32'd0);
        chk("mr_bad", 32'(bad_op), 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        offer(16'hFFFE, 3'b000, 32'h0000_0100);
        chk_out("mr_first", 32'hFFFF_FFFE, 32'h0000_0102, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("mr_empty", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, registered immediate-extension stage for the MIPS pipeline. It accepts an immediate, an extension op and the instruction PC through a valid/ready handshake. It produces the extended immediate and a PC-relative branch target one cycle later. A two-entry skid buffer decouples upstream from downstream backpressure, and a flush input supports branch/exception squash.

## Interface
Parameters:
- `IMM_W`, 16, immediate field width.
- `DATA_W`, 32, datapath width; must satisfy `DATA_W >= IMM_W + SHAMT`.
- `SHAMT`, 2, left-shift amount for word-offset modes.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous squash of all held entries.
- `in_valid` in 1: upstream offers a request.
- `in_ready` out 1: stage can accept this cycle.
- `imm` in `IMM_W`: raw immediate.
- `ext_op` in 3: extension mode.
- `pc` in `DATA_W`: PC of the owning instruction.
- `out_valid` out 1: result held.
- `out_ready` in 1: downstream consumes this cycle.
- `ext_imm` out `DATA_W`: extended immediate.
- `br_target` out `DATA_W`: `pc + 4 + ext_imm`, modulo 2^`DATA_W`.
- `bad_op` out 1: the current output came from a reserved `ext_op`.

## Operation
- Modes:
  - 000 SIGN: sign-extend `imm`.
  - 001 ZERO: zero-extend `imm`.
  - 010 HIGH: `imm` placed in the top `IMM_W` bits, low bits 0.
  - 011 SIGN_SHL: sign-extend, then shift left by `SHAMT`.
  - 100 ZERO_SHL: zero-extend, then shift left by `SHAMT`.
  - 101–111 reserved: `ext_imm` = 0, `br_target` = `pc + 4`, `bad_op` = 1 alongside that entry.
- Shifts are computed at full `DATA_W`; no bits are lost given the width rule.
- `br_target` is computed for every mode; the consumer decides whether to use it.
- Storage is a main register (drives the outputs) and one skid register, each holding `{valid, ext_imm, br_target, bad_op}`.
- `in_ready` = !`reset` && !`flush` && !`skid_valid`. It is combinational in registered state.
- On accept (`in_valid && in_ready`):
  - If main is empty, or main is valid and `out_ready` = 1, the result loads into main.
  - Otherwise it loads into skid.
- On consume (`out_valid && out_ready`), main refills in this priority order: from skid if skid is valid; else from a same-cycle accept; else main becomes empty.
- Ordering is strictly FIFO; the skid entry always precedes a newer accept.
- `flush` takes priority over accept and consume. Both valids clear at the next edge, and an offered input is not accepted. An output that is consumed while `flush` is high still counts as delivered.
- `reset` takes priority over `flush`.

## Timing
- Latency is 1 cycle from accept to `out_valid` when main is empty.
- Throughput is 1 per cycle while `out_ready` is held high.
- State after `reset`:
  - `out_valid` = 0.
  - `ext_imm` = 0, `br_target` = 0, `bad_op` = 0.
  - Skid empty.
  - `in_ready` = 1 in the first cycle after `reset` deasserts.
- Full condition: main and skid both valid → `in_ready` = 0 in the following cycle. It returns to 1 one cycle after the consume that drains skid.
- Outputs hold stable while `out_valid && !out_ready` (AXI-style). Data must not change under a stall.
- Reset mid-operation drops both entries with no partial output.
- Data registers may hold stale values when their valid bit is 0. They are not cleared on `flush`; only `reset` zeroes them.

## Structure
- Package `ext_pkg`: `ext_op_t` enum (SIGN, ZERO, HIGH, SIGN_SHL, ZERO_SHL) and a `EXT_OP_W` = 3 constant.
- Sub-module `ext_core`: purely combinational `imm`/`ext_op`/`pc` → `ext_imm`/`br_target`/`bad_op`, parameterised identically.
- The top level holds only the skid/handshake logic and instantiates one `ext_core` on the input side.

## Test plan
- Mode sweep with `out_ready` = 1, `pc` = 0x00003000 (each result one cycle after accept):
  - `imm` 0x8000 SIGN → 0xFFFF8000.
  - `imm` 0x8000 ZERO → 0x00008000.
  - `imm` 0x1234 HIGH → 0x12340000.
  - `imm` 0xFFFF SIGN_SHL → `ext_imm` 0xFFFFFFFC, `br_target` 0x00003000.
  - `imm` 0x0001 ZERO_SHL → 0x00000004.
- Backpressure: offer A, B, C back-to-back with `out_ready` = 0 for 3 cycles.
  - A is held in main and B in skid; `in_ready` drops, so C waits.
  - Raise `out_ready`: outputs A, B, C in consecutive cycles, with no loss or duplication.
- Flush: with main and skid full, assert `flush` for one cycle while `in_valid` = 1.
  - Next cycle `out_valid` = 0 and `in_ready` = 1.
  - The offered item is not accepted.
- Reserved op: `ext_op` = 111, `pc` = 0x00400000 → `ext_imm` 0, `br_target` 0x00400004, `bad_op` 1 for that entry only.
- Reset mid-stream: assert `reset` while both entries are valid.
  - Next cycle all outputs are 0 and `out_valid` = 0.
  - After release, the first accept returns a correct result at 1-cycle latency.
- Wrap-around: `pc` = 0xFFFFFFFC, SIGN `imm` 0x0010 → `br_target` 0x00000010.
